// File: rtl/wavetable_player.sv
// wavetable_player: fractional-phase wavetable sequencer (loop, one-shot, ping-pong) driving a single-port sample memory.
// Define WT_AMP_EN to add the amp port and an extra amplitude-scaling pipeline stage.
module wavetable_player #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 12,
  parameter int FRAC_W = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PH_W   = ADDR_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PH_W-1:0]   step,
  input  logic              next,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
`ifdef WT_AMP_EN
  input  logic [7:0]        amp,
`endif
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  // Table length, last-sample phase and twice that, all one bit wider than the phase
  localparam logic [PH_W:0] PH_L  = (PH_W+1)'(DEPTH << FRAC_W);
  localparam logic [PH_W:0] PH_M  = (PH_W+1)'((DEPTH - 1) << FRAC_W);
  localparam logic [PH_W:0] PH_M2 = (PH_W+1)'((DEPTH - 1) << (FRAC_W + 1));

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              dir_q, dir_d;
  logic [1:0]        mode_q, mode_d;
  logic              accept;
  logic              last;
  logic [PH_W:0]     sum;

  logic              rd_v;
  logic              rd_last;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    accept  = 1'b0;
    last    = 1'b0;
    sum     = {1'b0, phase_q} + {1'b0, step};
    if (start) begin
      state_d = ST_RUN;
      phase_d = '0;
      dir_d   = 1'b0;
      mode_d  = mode;
    end else if (state_q == ST_RUN && next) begin
      accept = 1'b1;
      case (mode_q)
        MODE_ONESHOT: begin
          if (sum >= PH_L) begin
            state_d = ST_DONE;
            last    = 1'b1;
          end else begin
            phase_d = PH_W'(sum);
          end
        end
        MODE_PINGPONG: begin
          // Reflect off either end of the table so the turnaround sample is not repeated
          if (!dir_q) begin
            if (sum > PH_M) begin
              phase_d = PH_W'(PH_M2 - sum);
              dir_d   = 1'b1;
            end else begin
              phase_d = PH_W'(sum);
            end
          end else begin
            if (phase_q < step) begin
              phase_d = step - phase_q;
              dir_d   = 1'b0;
            end else begin
              phase_d = phase_q - step;
            end
          end
        end
        default: begin
          if (sum >= PH_L) begin
            phase_d = PH_W'(sum - PH_L);
          end else begin
            phase_d = PH_W'(sum);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign mem_read = accept;
  assign mem_addr = phase_q[PH_W-1:FRAC_W];
  assign busy     = (state_q == ST_RUN);

`ifdef WT_AMP_EN
  logic              sc_v;
  logic              sc_last;
  logic [DATA_W-1:0] sc_data;
  logic [DATA_W+7:0] prod;

  assign prod = {8'b0, mem_data} * {{DATA_W{1'b0}}, amp};
`endif

  // Read-return pipeline; the last-sample flag travels with the read so done lines up with data_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v       <= 1'b0;
      rd_last    <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
`ifdef WT_AMP_EN
      sc_v       <= 1'b0;
      sc_last    <= 1'b0;
      sc_data    <= '0;
`endif
    end else begin
      rd_v    <= accept;
      rd_last <= last;
`ifdef WT_AMP_EN
      sc_v    <= rd_v;
      sc_last <= rd_last;
      if (rd_v) begin
        sc_data <= DATA_W'(prod >> 8);
      end
      data_valid <= sc_v;
      done       <= sc_v & sc_last;
      if (sc_v) begin
        data <= sc_data;
      end
`else
      data_valid <= rd_v;
      done       <= rd_v & rd_last;
      if (rd_v) begin
        data <= mem_data;
      end
`endif
    end
  end

endmodule
